// File: rtl/multicycle_main_cu_pkg.sv
// multicycle_main_cu_pkg: opcode, ALUop and select codes shared by the control unit and datapath
package multicycle_main_cu_pkg;
   localparam int OPW    = 4;
   localparam int STATEW = 4;
   localparam logic [OPW-1:0] OP_ADDI  = 4'b0000;
   localparam logic [OPW-1:0] OP_SUBI  = 4'b0001;
   localparam logic [OPW-1:0] OP_ANDI  = 4'b0010;
   localparam logic [OPW-1:0] OP_ORI   = 4'b0011;
   localparam logic [OPW-1:0] OP_LOAD  = 4'b0100;
   localparam logic [OPW-1:0] OP_STORE = 4'b0101;
   localparam logic [OPW-1:0] OP_JUMP  = 4'b0110;
   localparam logic [OPW-1:0] OP_BRZ   = 4'b0111;
   localparam logic [OPW-1:0] OP_CTYPE = 4'b1000;
   localparam logic [2:0] ALUOP_ADD = 3'b000;
   localparam logic [2:0] ALUOP_SUB = 3'b001;
   localparam logic [2:0] ALUOP_C   = 3'b010;
   localparam logic [2:0] ALUOP_AND = 3'b011;
   localparam logic [2:0] ALUOP_OR  = 3'b100;
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_JMP = 2'b01;
   typedef struct packed {
      logic [2:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pcsrc;
      logic       instr_done;
   } ctrl_t;
   function automatic logic op_legal(input logic [OPW-1:0] op);
      return op <= OP_CTYPE;
   endfunction
   function automatic logic is_imm(input logic [OPW-1:0] op);
      return op <= OP_ORI;
   endfunction
   function automatic logic [2:0] imm_aluop(input logic [OPW-1:0] op);
      return op == OP_SUBI ? ALUOP_SUB : op == OP_ANDI ? ALUOP_AND : op == OP_ORI ? ALUOP_OR : ALUOP_ADD;
   endfunction
endpackage

// File: rtl/multicycle_main_cu_if.sv
// multicycle_main_cu_if: status flags into, and datapath enables out of, the main control unit
interface multicycle_main_cu_if;
   logic [multicycle_main_cu_pkg::OPW-1:0] opcode;
   logic       zero;
   logic       notnoop;
   logic [2:0] ALUop;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       MemToReg;
   logic       PCWrite;
   logic       PCWriteCond;
   logic [1:0] PCSrc;
   logic       instr_done;
   modport master (
      input  opcode, zero, notnoop,
      output ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
             RegWrite, MemToReg, PCWrite, PCWriteCond, PCSrc, instr_done
   );
   modport slave (
      output opcode, zero, notnoop,
      input  ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
             RegWrite, MemToReg, PCWrite, PCWriteCond, PCSrc, instr_done
   );
endinterface

// File: rtl/multicycle_main_cu.sv
// multicycle_main_cu: main control FSM sequencing the accumulator datapath over 2-4 cycles per instruction
module multicycle_main_cu
   import multicycle_main_cu_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   multicycle_main_cu_if.master cu
);
   typedef enum logic [STATEW-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      IMM_EX  = 4'd2,
      IMM_WB  = 4'd3,
      C_EX    = 4'd4,
      C_WB    = 4'd5,
      LOAD_RD = 4'd6,
      LOAD_WB = 4'd7,
      STORE   = 4'd8,
      JUMP    = 4'd9,
      BRZ     = 4'd10
   } state_t;
   state_t state, nxt;
   ctrl_t  c;
   function automatic state_t dispatch(input logic [OPW-1:0] op);
      return is_imm(op)      ? IMM_EX  :
             op == OP_LOAD   ? LOAD_RD :
             op == OP_STORE  ? STORE   :
             op == OP_JUMP   ? JUMP    :
             op == OP_BRZ    ? BRZ     :
             op == OP_CTYPE  ? C_EX    : FETCH;
   endfunction
   always_ff @(posedge clk)
      state <= rst ? FETCH : nxt;
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:   nxt = DECODE;
         DECODE:  nxt = dispatch(cu.opcode);
         IMM_EX:  nxt = IMM_WB;
         C_EX:    nxt = C_WB;
         LOAD_RD: nxt = LOAD_WB;
         default: nxt = FETCH;
      endcase
   end
   // Opcode is held in IR from DECODE on, so IMM_EX and the illegal-op DECODE may read it.
   always_comb begin
      c = '0;
      case (state)
         FETCH: begin
            c.mem_read = 1'b1;
            c.ir_write = 1'b1;
            c.alusrcb  = SRCB_ONE;
            c.aluop    = ALUOP_ADD;
            c.pc_write = 1'b1;
            c.pcsrc    = PCSRC_ALU;
         end
         DECODE: c.instr_done = !op_legal(cu.opcode);
         IMM_EX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = imm_aluop(cu.opcode);
         end
         IMM_WB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         C_EX: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_B;
            c.aluop   = ALUOP_C;
         end
         C_WB: begin
            c.reg_write  = cu.notnoop;
            c.aluop      = ALUOP_C;
            c.instr_done = 1'b1;
         end
         LOAD_RD: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         LOAD_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         STORE: begin
            c.iord       = 1'b1;
            c.mem_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         JUMP: begin
            c.pc_write   = 1'b1;
            c.pcsrc      = PCSRC_JMP;
            c.instr_done = 1'b1;
         end
         BRZ: begin
            c.pc_write_cond = 1'b1;
            c.pcsrc         = PCSRC_JMP;
            c.instr_done    = 1'b1;
         end
         default: c = '0;
      endcase
      if (rst) c = '0;
   end
   assign cu.ALUop       = c.aluop;
   assign cu.ALUSrcA     = c.alusrca;
   assign cu.ALUSrcB     = c.alusrcb;
   assign cu.IorD        = c.iord;
   assign cu.MemRead     = c.mem_read;
   assign cu.MemWrite    = c.mem_write;
   assign cu.IRWrite     = c.ir_write;
   assign cu.RegWrite    = c.reg_write;
   assign cu.MemToReg    = c.mem_to_reg;
   assign cu.PCWrite     = c.pc_write;
   assign cu.PCWriteCond = c.pc_write_cond;
   assign cu.PCSrc       = c.pcsrc;
   assign cu.instr_done  = c.instr_done;
   a_mem_excl: assert property (@(posedge clk) disable iff (rst) !(c.mem_read && c.mem_write));
   a_pc_excl:  assert property (@(posedge clk) disable iff (rst) !(c.pc_write && c.pc_write_cond));
endmodule

// File: tb/tb_multicycle_main_cu.sv
// tb_multicycle_main_cu: cycle-vector table with a scoreboard queue and a PC model for jumps/branches
module tb_multicycle_main_cu;
   typedef struct packed {
      logic [2:0] aluop;
      logic       srca;
      logic [1:0] srcb;
      logic       iord, mr, mw, irw, rw, m2r, pcw, pcwc;
      logic [1:0] pcsrc;
      logic       done;
   } exp_t;
   typedef struct {
      logic       rst;
      logic [3:0] op;
      logic       z;
      logic       nn;
      exp_t       e;
      logic       chk_pc;
      int         pc;
      string      tag;
   } vec_t;
   localparam int TARGET = 171;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   multicycle_main_cu_if cu();
   multicycle_main_cu dut (.clk(clk), .rst(rst), .cu(cu));
   vec_t vecs[$];
   vec_t sb[$];
   exp_t cf, c0;
   int checks = 0, failures = 0, bpc = 0, pc = 0, n_done = 0, exp_done = 0;
   task automatic add(input logic r, input logic [3:0] op, input logic z, input logic nn,
                      input exp_t e, input logic chk, input string tag);
      vec_t v;
      v.rst = r; v.op = op; v.z = z; v.nn = nn; v.e = e; v.chk_pc = chk; v.pc = bpc; v.tag = tag;
      if (e.done) exp_done++;
      vecs.push_back(v);
   endtask
   task automatic instr(input logic [3:0] op, input logic z, input logic nn, input string tag);
      exp_t e;
      add(1'b0, op, z, nn, cf, 1'b0, {tag, "_f"});
      bpc++;
      e = c0;
      e.done = op > 4'd8;
      add(1'b0, op, z, nn, e, op > 4'd8, {tag, "_d"});
      e = c0;
      if (op <= 4'd3) begin
         e.srca = 1'b1; e.srcb = 2'b10;
         e.aluop = op == 4'd0 ? 3'b000 : op == 4'd1 ? 3'b001 : op == 4'd2 ? 3'b011 : 3'b100;
         add(1'b0, op, z, nn, e, 1'b0, {tag, "_ex"});
         e = c0; e.rw = 1'b1; e.done = 1'b1;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_wb"});
      end else if (op == 4'd4) begin
         e.iord = 1'b1; e.mr = 1'b1;
         add(1'b0, op, z, nn, e, 1'b0, {tag, "_rd"});
         e = c0; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_wb"});
      end else if (op == 4'd5) begin
         e.iord = 1'b1; e.mw = 1'b1; e.done = 1'b1;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_st"});
      end else if (op == 4'd6) begin
         e.pcw = 1'b1; e.pcsrc = 2'b01; e.done = 1'b1;
         bpc = TARGET;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_j"});
      end else if (op == 4'd7) begin
         e.pcwc = 1'b1; e.pcsrc = 2'b01; e.done = 1'b1;
         if (z) bpc = TARGET;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_br"});
      end else if (op == 4'd8) begin
         e.srca = 1'b1; e.srcb = 2'b00; e.aluop = 3'b010;
         add(1'b0, op, z, nn, e, 1'b0, {tag, "_ex"});
         e = c0; e.rw = nn; e.aluop = 3'b010; e.done = 1'b1;
         add(1'b0, op, z, nn, e, 1'b1, {tag, "_wb"});
      end
   endtask
   always @(negedge clk) begin
      vec_t v;
      exp_t a;
      if (sb.size() > 0) begin
         v = sb.pop_front();
         a = {cu.ALUop, cu.ALUSrcA, cu.ALUSrcB, cu.IorD, cu.MemRead, cu.MemWrite, cu.IRWrite,
              cu.RegWrite, cu.MemToReg, cu.PCWrite, cu.PCWriteCond, cu.PCSrc, cu.instr_done};
         checks++;
         if (a !== v.e) begin
            failures++;
            $display("FAIL %s ctrl got=%05h exp=%05h", v.tag, a, v.e);
         end
         if (a.done === 1'b1) n_done++;
         if (a.pcw === 1'b1 || (a.pcwc === 1'b1 && cu.zero)) pc = a.pcsrc == 2'b01 ? TARGET : pc + 1;
         if (v.chk_pc) begin
            checks++;
            if (pc != v.pc) begin
               failures++;
               $display("FAIL %s pc got=%0d exp=%0d", v.tag, pc, v.pc);
            end
         end
      end
   end
   initial begin
      cu.opcode = 4'd0;
      cu.zero = 1'b0;
      cu.notnoop = 1'b0;
      c0 = '0;
      cf = '0;
      cf.mr = 1'b1; cf.irw = 1'b1; cf.srcb = 2'b01; cf.pcw = 1'b1;
      add(1'b1, 4'd0, 1'b0, 1'b0, c0, 1'b0, "rst0");
      add(1'b1, 4'd0, 1'b0, 1'b0, c0, 1'b0, "rst1");
      instr(4'd0, 1'b0, 1'b0, "addi");
      instr(4'd1, 1'b1, 1'b0, "subi");
      instr(4'd2, 1'b0, 1'b1, "andi");
      instr(4'd3, 1'b0, 1'b0, "ori");
      instr(4'd8, 1'b0, 1'b1, "ctype");
      instr(4'd8, 1'b0, 1'b0, "cnop");
      instr(4'd7, 1'b1, 1'b0, "brz_t");
      instr(4'd7, 1'b0, 1'b0, "brz_n");
      instr(4'd4, 1'b0, 1'b0, "load");
      instr(4'd5, 1'b0, 1'b0, "store");
      instr(4'd6, 1'b0, 1'b0, "jump");
      instr(4'd15, 1'b0, 1'b0, "ill15");
      instr(4'd9, 1'b1, 1'b1, "ill9");
      add(1'b0, 4'd8, 1'b0, 1'b1, cf, 1'b0, "rmid_f");
      bpc++;
      add(1'b0, 4'd8, 1'b0, 1'b1, c0, 1'b0, "rmid_d");
      add(1'b1, 4'd8, 1'b0, 1'b1, c0, 1'b1, "rmid_ex");
      instr(4'd8, 1'b0, 1'b1, "after_rst");
      instr(4'd7, 1'b1, 1'b0, "brz_t2");
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst = vecs[i].rst;
         cu.opcode = vecs[i].op;
         cu.zero = vecs[i].z;
         cu.notnoop = vecs[i].nn;
         sb.push_back(vecs[i]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      checks++;
      if (n_done != exp_done) begin
         failures++;
         $display("FAIL done_count got=%0d exp=%0d", n_done, exp_done);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
